uart_tx_buffer: RTL and testbench

Synchronous byte FIFO placed directly upstream of the UART transmitter. Host-side logic pushes bytes at its own pace; the buffer presents them one at a time on a valid/ready interface that connects straight to the transmitter's valid_tx_in / data_tx_in / ready_tx_out pins. It decouples bursty producers from the slow serial line and reports occupancy and overflow.

---
 rtl/uart_tx_buffer.sv | 99 +++++++++
 tb/tb_uart_tx_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter: host-side push interface, valid/ready
// head-of-queue interface toward the transmitter, occupancy count and sticky overflow.
module uart_tx_buffer #(
    parameter int BYTESIZES = 8,
    parameter int DEPTH     = 16,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_in,
    input  logic                 wr_valid_in,
    input  logic [BYTESIZES-1:0] wr_data_in,
    output logic                 wr_ready_out,
    output logic                 valid_tx_out,
    output logic [BYTESIZES-1:0] data_tx_out,
    input  logic                 ready_tx_in,
    output logic [CW-1:0]        count_out,
    output logic                 overflow_out
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTESIZES-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 overflow_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 clear_s;
    logic [CW-1:0]        count_nxt_s;
    logic [BYTESIZES-1:0] head_s;

    // Handshake qualification; a full buffer never accepts, even with a pop pending.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == {CW{1'b0}});
        clear_s = reset | flush_in;
        push_s  = wr_valid_in & ~full_s;
        pop_s   = ready_tx_in & ~empty_s;
    end

    // Occupancy next-state: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and sticky overflow registers; reset and flush dominate handshakes.
    always_ff @(posedge clock) begin
        if (clear_s) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            if (wr_valid_in && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are left untouched by reset and flush.
    always_ff @(posedge clock) begin
        if (push_s && !clear_s) begin
            mem_r[wr_ptr_r] <= wr_data_in;
        end
    end

    // Head byte is forced to zero while empty so stale entries never leak out.
    always_comb begin
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {BYTESIZES{1'b0}};
        end
    end

    assign wr_ready_out = ~full_s;
    assign valid_tx_out = ~empty_s;
    assign data_tx_out  = head_s;
    assign count_out    = count_r;
    assign overflow_out = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_buffer;

    localparam int BW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush_in = 1'b0;
    logic          wr_valid_in = 1'b0;
    logic [BW-1:0] wr_data_in = 8'h00;
    logic          wr_ready_out;
    logic          valid_tx_out;
    logic [BW-1:0] data_tx_out;
    logic          ready_tx_in = 1'b0;
    logic [CW-1:0] count_out;
    logic          overflow_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [BW-1:0] q_m[$];
    logic [BW-1:0] out_log[$];
    logic [BW-1:0] sent[$];
    bit            ov_m = 1'b0;

    uart_tx_buffer #(.BYTESIZES(BW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush_in     (flush_in),
        .wr_valid_in  (wr_valid_in),
        .wr_data_in   (wr_data_in),
        .wr_ready_out (wr_ready_out),
        .valid_tx_out (valid_tx_out),
        .data_tx_out  (data_tx_out),
        .ready_tx_in  (ready_tx_in),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, decisions taken from occupancy before the edge.
    always @(posedge clock) begin
        if (reset || flush_in) begin
            q_m.delete();
            ov_m = 1'b0;
        end else begin
            int  n;
            n = q_m.size();
            if (wr_valid_in && n == DEPTH) ov_m = 1'b1;
            if (ready_tx_in && n > 0) out_log.push_back(q_m.pop_front());
            if (wr_valid_in && n < DEPTH) q_m.push_back(wr_data_in);
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("m_count", 32'(count_out), 32'(q_m.size()));
            check("m_wr_ready", 32'(wr_ready_out), 32'(q_m.size() != DEPTH));
            check("m_valid", 32'(valid_tx_out), 32'(q_m.size() != 0));
            check("m_data", 32'(data_tx_out), (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0);
            check("m_overflow", 32'(overflow_out), 32'(ov_m));
        end
    end

    task automatic cyc(input bit wv, input logic [BW-1:0] wd, input bit rdy, input bit fl);
        wr_valid_in = wv;
        wr_data_in  = wd;
        ready_tx_in = rdy;
        flush_in    = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [BW-1:0] b;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_wr_ready", 32'(wr_ready_out), 32'd1);
        check("rst_valid", 32'(valid_tx_out), 32'd0);
        check("rst_data", 32'(data_tx_out), 32'd0);
        check("rst_overflow", 32'(overflow_out), 32'd0);

        // Single byte, held until the transmitter accepts it
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        check("t1_valid", 32'(valid_tx_out), 32'd1);
        check("t1_data", 32'(data_tx_out), 32'h78);
        check("t1_count", 32'(count_out), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_hold_data", 32'(data_tx_out), 32'h78);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_pop_valid", 32'(valid_tx_out), 32'd0);
        check("t1_pop_count", 32'(count_out), 32'd0);
        check("t1_pop_data", 32'(data_tx_out), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("t2_full_count", 32'(count_out), 32'd16);
        check("t2_full_ready", 32'(wr_ready_out), 32'd0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t2_overflow", 32'(overflow_out), 32'd1);
        check("t2_ovf_count", 32'(count_out), 32'd16);
        out_log.delete();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_drain_len", 32'(out_log.size()), 32'd16);
        for (int i = 0; i < out_log.size(); i++) check("t2_drain_byte", 32'(out_log[i]), 32'(i));
        check("t2_sticky_ovf", 32'(overflow_out), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_flush_ovf", 32'(overflow_out), 32'd0);

        // Full with simultaneous write and pop: pop only, then write accepted
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b1, 1'b0);
        check("t3_count15", 32'(count_out), 32'd15);
        check("t3_ready", 32'(wr_ready_out), 32'd1);
        check("t3_head", 32'(data_tx_out), 32'h31);
        cyc(1'b1, 8'hCC, 1'b0, 1'b0);
        check("t3_count16", 32'(count_out), 32'd16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming push+pop with count held at 2; pointers wrap several times
        out_log.delete();
        sent.delete();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            cyc(1'b1, b, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            cyc(1'b1, b, 1'b1, 1'b0);
            if (count_out != 5'd2) check("t4_count_held", 32'(count_out), 32'd2);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_len", 32'(out_log.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < out_log.size(); i++)
            check("t4_byte", 32'(out_log[i]), 32'(sent[i]));

        // Empty buffer with write and ready together: push only
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        check("t5_count", 32'(count_out), 32'd1);
        check("t5_data", 32'(data_tx_out), 32'h5A);

        // Flush mid-stream beats concurrent handshakes
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        check("t6_count", 32'(count_out), 32'd0);
        check("t6_valid", 32'(valid_tx_out), 32'd0);
        check("t6_overflow", 32'(overflow_out), 32'd0);
        check("t6_data", 32'(data_tx_out), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        reset = 1'b0;
        check("t7_count", 32'(count_out), 32'd0);
        check("t7_ready", 32'(wr_ready_out), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
